// File: rtl/max_no_pkg.sv
// ---------------------------------------------------------------------------
// max_no_pkg
// Shared definitions for the max_no comparator and its serial-to-parallel
// lane packer front end.
//   DEFAULT_LANES : default number of lanes per packed vector
//   DEFAULT_WIDTH : default bits per sample/lane
//   pack_state_t  : packer state (FILL = collecting, HOLD = vector presented)
//   lane_t        : one lane of the vector handed to max_no.data_in
// ---------------------------------------------------------------------------
package max_no_pkg;

  localparam int DEFAULT_LANES = 4;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  typedef logic [DEFAULT_WIDTH-1:0] lane_t;

endpackage

// File: rtl/max_no_lane_packer.sv
// ---------------------------------------------------------------------------
// max_no_lane_packer
// Serial-to-parallel front end for the max_no comparator. Takes one sample per
// valid/ready beat and packs LANES samples into an unpacked vector, then
// presents that vector with valid/ready and holds it until it is accepted.
// in_last flushes a partial vector; lanes that were never written read as
// zero, which cannot win an unsigned max.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : a sample is present on in_data
//   in_data    : sample value
//   in_last    : sample closes the current group (flush after it)
//   in_ready   : packer takes a sample this cycle
//   out_valid  : data_out/lane_mask hold a complete vector
//   data_out   : packed lanes, lane 0 = first sample of the vector
//   lane_mask  : bit i set = lane i holds a real sample
//   out_ready  : consumer takes the presented vector this cycle
// ---------------------------------------------------------------------------
module max_no_lane_packer
  import max_no_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out [LANES],
  output logic [LANES-1:0] lane_mask,
  input  logic             out_ready
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  pack_state_t      state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] lanes_q [LANES];
  logic [WIDTH-1:0] lanes_d [LANES];
  logic [LANES-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;
  logic             accept;

  // A sample can be taken while collecting, or while presenting a vector in
  // the same cycle the consumer retires it. Reset blocks the input side.
  assign in_ready = !rst && ((state_q == FILL) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Next-state logic for the FSM, write index, lane registers and mask.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    mask_d  = mask_q;
    valid_d = valid_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          lanes_d[idx_q] = in_data;
          mask_d[idx_q]  = 1'b1;
          if ((idx_q == LAST_IDX) || in_last) begin
            state_d = HOLD;
            valid_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          // Retiring the presented vector always starts from a clean slate so
          // stale lanes never leak into the next vector.
          for (int i = 0; i < LANES; i++) begin
            lanes_d[i] = '0;
          end
          mask_d = '0;
          if (accept) begin
            // Back-to-back: the incoming sample becomes lane 0 of the next
            // vector in the same cycle the old one leaves.
            lanes_d[0] = in_data;
            mask_d[0]  = 1'b1;
            if (in_last || (LANES == 1)) begin
              state_d = HOLD;
              valid_d = 1'b1;
              idx_d   = '0;
            end else begin
              state_d = FILL;
              valid_d = 1'b0;
              idx_d   = IW'(1);
            end
          end else begin
            state_d = FILL;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial or presented vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= lanes_d[i];
      end
    end
  end

  assign out_valid = valid_q;
  assign lane_mask = mask_q;
  assign data_out  = lanes_q;

endmodule
